hazard_fwd_ctrl: RTL and testbench
==================================

HAZARD_FWD_CTRL -- requirements
Module: hazard_fwd_ctrl

Interface
REQ-001 SHALL have one clock, `clk`, and a synchronous active-high reset, `rst`; every flop samples on the posedge of `clk`.
REQ-002 `clk`  in  1  pipeline clock.
REQ-003 `rst`  in  1  synchronous reset, active high.
REQ-004 `dA_rs1_addr`/`dA_rs2_addr`/`dA_rd_addr`  in  5 each  issue-A source/destination registers of the bundle in ID.
REQ-005 `dA_rs1_active`/`dA_rs2_active`/`dA_reg_write`/`dA_is_load`  in  1 each  issue-A ID qualifiers.
REQ-006 `dB_*`  in  same set and widths as `dA_*`  issue-B ID fields; B is younger than A in program order.
REQ-007 `br_flush`  in  1  branch redirect resolved in EX; kills the ID bundle and both EX slots.
REQ-008 `A_fwd_src1`/`A_fwd_src2`/`B_fwd_src1`/`B_fwd_src2`  out  3 each  forwarding selects for the EX operand muxes.
REQ-009 `if_id_hold`  out  1  freeze PC and the IF/ID register.
REQ-010 `A_bubble`/`B_bubble`  out  1 each  zero the ID/EX control of the slot (reg_write=0, mem_write=0).
REQ-011 `A_flush`/`B_flush`  out  1 each  drive the EX/MEM flush inputs of the execute stage.

Function
REQ-012 Forward-select encoding SHALL be: REG_DATA=0, A_FWD_MEM=1, A_FWD_WB=2, B_FWD_MEM=3, B_FWD_WB=4; 5-7 are unused.
REQ-013 SHALL keep internal tracking registers for slots A and B in EX, MEM and WB: rd[4:0], reg_write, is_load, plus rs1/rs2 address and active for EX.
REQ-014 Tracking SHALL advance every cycle: ID→EX takes the ID fields, with reg_write forced to 0 when that slot's bubble is 1; EX→MEM→WB shifts unconditionally.
REQ-015 Selects SHALL be combinational from the registered EX/MEM/WB tracking only, with no ID-to-select path; zero-cycle latency relative to the EX instruction.
REQ-016 A select SHALL be REG_DATA when the source is inactive or its address is 0.
REQ-017 Otherwise the first match wins, in this priority order: B_FWD_MEM > A_FWD_MEM > B_FWD_WB > A_FWD_WB > REG_DATA. A match requires reg_write=1 and an equal rd.
REQ-018 A MEM-stage producer with is_load=1 SHALL NOT be selected; the stalls in REQ-020 guarantee this case never occurs for a live consumer.
REQ-019 FSM states SHALL be IDLE, LD_STALL, SPLIT_B and SPLIT_WAIT (2-bit encoding).
REQ-020 IDLE with `dep_ld` SHALL go to LD_STALL, with `if_id_hold`=1 and both bubbles=1. `dep_ld` means an EX slot has is_load, reg_write and rd≠0, and its rd equals an active ID source of A or B.
REQ-021 LD_STALL SHALL return to IDLE after 1 cycle and re-evaluate the bundle on the following cycle.
REQ-022 IDLE with no `dep_ld` but with `dep_ab` SHALL issue A only: `B_bubble`=1 and `if_id_hold`=1. `dep_ab` means `dB` has an active source equal to `dA_rd`, with `dA_reg_write` and `dA_rd`≠0. Next state is SPLIT_WAIT if `dA_is_load`, else SPLIT_B.
REQ-023 SPLIT_WAIT SHALL assert both bubbles and `if_id_hold` for 1 cycle, then go to SPLIT_B.
REQ-024 SPLIT_B SHALL assert `A_bubble`=1, issue B, hold `if_id_hold`=0, and go to IDLE.
REQ-025 A bundle with no dependence SHALL issue both slots with hold=0 and bubbles=0.
REQ-026 `br_flush` SHALL override everything: that cycle, `A_flush`=`B_flush`=1 and both bubbles=1; the FSM goes to IDLE; `if_id_hold`=0 so the redirect fetch proceeds.
REQ-027 `A_flush`/`B_flush` SHALL equal `br_flush` in every cycle.
REQ-028 `rst` asserted mid-stall SHALL abandon the split or stall; the bundle is not reissued by this block.

Reset
REQ-029 On reset: FSM=IDLE; all tracking reg_write and is_load=0; rd and source addresses=0.
REQ-030 On reset: all selects=REG_DATA, `if_id_hold`=0, bubbles=0, flushes=0.
REQ-031 The first post-reset cycle SHALL issue with no forwarding.

Structure
REQ-032 The select encodings, the FSM state encoding and the tracking record SHALL live in the shared package `cpu_defs`. The encodings are also used by the execute stage.
REQ-033 There SHALL be one sub-module, `fwd_sel`: a combinational 4-candidate priority comparator instantiated 4 times (A/B × src1/src2).

Verification
REQ-034 `A: add x5` then next bundle `A: sub x6,x5,x1` → on the cycle sub is in EX, `A_fwd_src1`=1. One cycle later, with a consumer of x5 in EX, the select is 2.
REQ-035 Same bundle with A writing x7 and B writing x7, next bundle reads x7 → select=3 (B_FWD_MEM beats A_FWD_MEM).
REQ-036 `A: lw x8` then `B: add x9,x8,x8` → one LD_STALL cycle (hold=1, bubbles=11). B then executes with `B_fwd_src1`=`B_fwd_src2`=2.
REQ-037 Bundle `A: addi x3`, `B: add x4,x3,x0` → cycle 1 `B_bubble`=1 and hold=1; cycle 2 `A_bubble`=1, `B_fwd_src1`=1, and `B_fwd_src2`=0 because x0 is never forwarded.
REQ-038 Bundle `A: lw x3`, `B: use x3` → sequence SPLIT_WAIT then SPLIT_B; B's select=2.
REQ-039 `br_flush` raised during SPLIT_WAIT → the same cycle gives flushes=11 and bubbles=11; the FSM is IDLE the next cycle and the later select shows no stale match.

Source files
------------

// File: rtl/hazard_fwd_ctrl_pkg.sv
// Shared pipeline definitions: forwarding-select encoding, hazard FSM states
// and the per-slot tracking records used by the hazard/forwarding control.
package cpu_defs;

  typedef enum logic [2:0] {
    REG_DATA  = 3'd0,
    A_FWD_MEM = 3'd1,
    A_FWD_WB  = 3'd2,
    B_FWD_MEM = 3'd3,
    B_FWD_WB  = 3'd4
  } fwd_sel_e;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    LD_STALL   = 2'd1,
    SPLIT_B    = 2'd2,
    SPLIT_WAIT = 2'd3
  } hz_state_e;

  typedef struct packed {
    logic [4:0] rd;
    logic       reg_write;
    logic       is_load;
  } trk_t;

  typedef struct packed {
    trk_t       dst;
    logic [4:0] rs1;
    logic       rs1_active;
    logic [4:0] rs2;
    logic       rs2_active;
  } ex_trk_t;

  // True when an active, non-x0 source reads the register a live producer writes.
  function automatic logic src_hit(logic [4:0] addr, logic active, trk_t p);
    return active && p.reg_write && (p.rd != '0) && (addr == p.rd);
  endfunction

  function automatic ex_trk_t make_ex(logic [4:0] rs1, logic a1, logic [4:0] rs2,
                                      logic a2, logic [4:0] rd, logic rw, logic ld);
    ex_trk_t e;
    e.dst.rd        = rd;
    e.dst.reg_write = rw;
    e.dst.is_load   = ld;
    e.rs1           = rs1;
    e.rs1_active    = a1;
    e.rs2           = rs2;
    e.rs2_active    = a2;
    return e;
  endfunction

endpackage

// File: rtl/hazard_fwd_ctrl_if.sv
// ID-stage bundle fields in, forwarding selects and stall/flush controls out.
interface hazard_fwd_ctrl_if;
  logic [4:0] dA_rs1_addr, dA_rs2_addr, dA_rd_addr;
  logic       dA_rs1_active, dA_rs2_active, dA_reg_write, dA_is_load;
  logic [4:0] dB_rs1_addr, dB_rs2_addr, dB_rd_addr;
  logic       dB_rs1_active, dB_rs2_active, dB_reg_write, dB_is_load;
  logic       br_flush;
  logic [2:0] A_fwd_src1, A_fwd_src2, B_fwd_src1, B_fwd_src2;
  logic       if_id_hold, A_bubble, B_bubble, A_flush, B_flush;

  modport master (
    output dA_rs1_addr, dA_rs2_addr, dA_rd_addr,
           dA_rs1_active, dA_rs2_active, dA_reg_write, dA_is_load,
           dB_rs1_addr, dB_rs2_addr, dB_rd_addr,
           dB_rs1_active, dB_rs2_active, dB_reg_write, dB_is_load,
           br_flush,
    input  A_fwd_src1, A_fwd_src2, B_fwd_src1, B_fwd_src2,
           if_id_hold, A_bubble, B_bubble, A_flush, B_flush
  );

  modport slave (
    input  dA_rs1_addr, dA_rs2_addr, dA_rd_addr,
           dA_rs1_active, dA_rs2_active, dA_reg_write, dA_is_load,
           dB_rs1_addr, dB_rs2_addr, dB_rd_addr,
           dB_rs1_active, dB_rs2_active, dB_reg_write, dB_is_load,
           br_flush,
    output A_fwd_src1, A_fwd_src2, B_fwd_src1, B_fwd_src2,
           if_id_hold, A_bubble, B_bubble, A_flush, B_flush
  );
endinterface

// File: rtl/hazard_fwd_ctrl_fwd_sel.sv
// Priority comparator picking the youngest live producer of one EX operand.
module fwd_sel
  import cpu_defs::*;
(
  input  logic [4:0] src_addr,
  input  logic       src_active,
  input  trk_t       mem_b,
  input  trk_t       mem_a,
  input  trk_t       wb_b,
  input  trk_t       wb_a,
  output fwd_sel_e   sel
);

  // Loads still in MEM have no data yet, so they are never a forwarding source.
  function automatic logic usable(trk_t p, logic in_mem);
    return src_hit(src_addr, src_active, p) && !(in_mem && p.is_load);
  endfunction

  always_comb begin
    sel = REG_DATA;
    if (usable(mem_b, 1'b1))      sel = B_FWD_MEM;
    else if (usable(mem_a, 1'b1)) sel = A_FWD_MEM;
    else if (usable(wb_b, 1'b0))  sel = B_FWD_WB;
    else if (usable(wb_a, 1'b0))  sel = A_FWD_WB;
  end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Dual-issue hazard control: load-use stalls, intra-bundle splits, branch
// flush, and operand forwarding selects derived from EX/MEM/WB tracking.
module hazard_fwd_ctrl
  import cpu_defs::*;
(
  input  logic               clk,
  input  logic               rst,
  hazard_fwd_ctrl_if.slave   bus
);

  hz_state_e st, st_nxt;
  ex_trk_t   ex_a, ex_b;
  trk_t      mem_a, mem_b, wb_a, wb_b;
  trk_t      id_a;
  logic      dep_ld, dep_ab, hold, a_bub, b_bub;
  fwd_sel_e  a1_sel, a2_sel, b1_sel, b2_sel;

  function automatic logic ld_hit(trk_t p);
    return p.is_load &&
           (src_hit(bus.dA_rs1_addr, bus.dA_rs1_active, p) ||
            src_hit(bus.dA_rs2_addr, bus.dA_rs2_active, p) ||
            src_hit(bus.dB_rs1_addr, bus.dB_rs1_active, p) ||
            src_hit(bus.dB_rs2_addr, bus.dB_rs2_active, p));
  endfunction

  always_comb begin
    id_a.rd        = bus.dA_rd_addr;
    id_a.reg_write = bus.dA_reg_write;
    id_a.is_load   = bus.dA_is_load;
    dep_ld = ld_hit(ex_a.dst) || ld_hit(ex_b.dst);
    dep_ab = src_hit(bus.dB_rs1_addr, bus.dB_rs1_active, id_a) ||
             src_hit(bus.dB_rs2_addr, bus.dB_rs2_active, id_a);
  end

  // LD_STALL decides like IDLE: its EX slots are bubbles, so the held bundle
  // is re-evaluated only for an intra-bundle dependence.
  always_comb begin
    st_nxt = st;
    hold   = 1'b0;
    a_bub  = 1'b0;
    b_bub  = 1'b0;
    if (bus.br_flush) begin
      a_bub  = 1'b1;
      b_bub  = 1'b1;
      st_nxt = IDLE;
    end else begin
      case (st)
        IDLE, LD_STALL: begin
          if (dep_ld) begin
            hold   = 1'b1;
            a_bub  = 1'b1;
            b_bub  = 1'b1;
            st_nxt = LD_STALL;
          end else if (dep_ab) begin
            hold   = 1'b1;
            b_bub  = 1'b1;
            st_nxt = bus.dA_is_load ? SPLIT_WAIT : SPLIT_B;
          end else begin
            st_nxt = IDLE;
          end
        end
        SPLIT_WAIT: begin
          hold   = 1'b1;
          a_bub  = 1'b1;
          b_bub  = 1'b1;
          st_nxt = SPLIT_B;
        end
        SPLIT_B: begin
          a_bub  = 1'b1;
          st_nxt = IDLE;
        end
      endcase
    end
  end

  // The shift is unconditional; a flush only clears the killed EX entries'
  // qualifiers so they cannot later appear as MEM/WB producers.
  always_ff @(posedge clk) begin
    if (rst) begin
      st    <= IDLE;
      ex_a  <= '0;
      ex_b  <= '0;
      mem_a <= '0;
      mem_b <= '0;
      wb_a  <= '0;
      wb_b  <= '0;
    end else begin
      st    <= st_nxt;
      ex_a  <= make_ex(bus.dA_rs1_addr, bus.dA_rs1_active, bus.dA_rs2_addr,
                       bus.dA_rs2_active, bus.dA_rd_addr,
                       bus.dA_reg_write & ~a_bub, bus.dA_is_load);
      ex_b  <= make_ex(bus.dB_rs1_addr, bus.dB_rs1_active, bus.dB_rs2_addr,
                       bus.dB_rs2_active, bus.dB_rd_addr,
                       bus.dB_reg_write & ~b_bub, bus.dB_is_load);
      mem_a.rd        <= ex_a.dst.rd;
      mem_a.reg_write <= ex_a.dst.reg_write & ~bus.br_flush;
      mem_a.is_load   <= ex_a.dst.is_load & ~bus.br_flush;
      mem_b.rd        <= ex_b.dst.rd;
      mem_b.reg_write <= ex_b.dst.reg_write & ~bus.br_flush;
      mem_b.is_load   <= ex_b.dst.is_load & ~bus.br_flush;
      wb_a  <= mem_a;
      wb_b  <= mem_b;
    end
  end

  fwd_sel u_a1 (.src_addr(ex_a.rs1), .src_active(ex_a.rs1_active), .mem_b(mem_b),
                .mem_a(mem_a), .wb_b(wb_b), .wb_a(wb_a), .sel(a1_sel));
  fwd_sel u_a2 (.src_addr(ex_a.rs2), .src_active(ex_a.rs2_active), .mem_b(mem_b),
                .mem_a(mem_a), .wb_b(wb_b), .wb_a(wb_a), .sel(a2_sel));
  fwd_sel u_b1 (.src_addr(ex_b.rs1), .src_active(ex_b.rs1_active), .mem_b(mem_b),
                .mem_a(mem_a), .wb_b(wb_b), .wb_a(wb_a), .sel(b1_sel));
  fwd_sel u_b2 (.src_addr(ex_b.rs2), .src_active(ex_b.rs2_active), .mem_b(mem_b),
                .mem_a(mem_a), .wb_b(wb_b), .wb_a(wb_a), .sel(b2_sel));

  assign bus.A_fwd_src1 = a1_sel;
  assign bus.A_fwd_src2 = a2_sel;
  assign bus.B_fwd_src1 = b1_sel;
  assign bus.B_fwd_src2 = b2_sel;
  assign bus.if_id_hold = hold & ~rst;
  assign bus.A_bubble   = a_bub & ~rst;
  assign bus.B_bubble   = b_bub & ~rst;
  assign bus.A_flush    = bus.br_flush;
  assign bus.B_flush    = bus.br_flush;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed bench for hazard_fwd_ctrl: forwarding priority, load-use stall,
// bundle splits, branch flush and reset abandonment.
module tb_hazard_fwd_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  hazard_fwd_ctrl_if bus ();

  hazard_fwd_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed %b expected %b", tag, obs, exp);
      end
  endtask

  // ctl = {if_id_hold, A_bubble, B_bubble, A_flush, B_flush}
  task automatic chk_ctl(input string tag, input logic [4:0] exp);
    #1;
    chk(tag, {bus.if_id_hold, bus.A_bubble, bus.B_bubble, bus.A_flush, bus.B_flush}, exp);
  endtask

  task automatic chk_sel(input string tag, input logic [2:0] a1, input logic [2:0] a2,
                         input logic [2:0] b1, input logic [2:0] b2);
    #1;
    chk({tag, "_A1"}, {2'b00, bus.A_fwd_src1}, {2'b00, a1});
    chk({tag, "_A2"}, {2'b00, bus.A_fwd_src2}, {2'b00, a2});
    chk({tag, "_B1"}, {2'b00, bus.B_fwd_src1}, {2'b00, b1});
    chk({tag, "_B2"}, {2'b00, bus.B_fwd_src2}, {2'b00, b2});
  endtask

  task automatic set_a(input logic [4:0] rs1, input logic a1, input logic [4:0] rs2,
                       input logic a2, input logic [4:0] rd, input logic rw, input logic ld);
    bus.dA_rs1_addr = rs1; bus.dA_rs1_active = a1;
    bus.dA_rs2_addr = rs2; bus.dA_rs2_active = a2;
    bus.dA_rd_addr  = rd;  bus.dA_reg_write  = rw; bus.dA_is_load = ld;
  endtask

  task automatic set_b(input logic [4:0] rs1, input logic a1, input logic [4:0] rs2,
                       input logic a2, input logic [4:0] rd, input logic rw, input logic ld);
    bus.dB_rs1_addr = rs1; bus.dB_rs1_active = a1;
    bus.dB_rs2_addr = rs2; bus.dB_rs2_active = a2;
    bus.dB_rd_addr  = rd;  bus.dB_reg_write  = rw; bus.dB_is_load = ld;
  endtask

  task automatic nop_bundle();
    set_a(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    set_b(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    bus.br_flush = 1'b0;
    // Dependent bundle presented during reset must not stall
    set_a(5'd1, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0);
    set_b(5'd3, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0);
    tick();
    chk_ctl("rst_ctl", 5'b00000);
    chk_sel("rst_sel", 3'd0, 3'd0, 3'd0, 3'd0);
    tick();
    rst = 1'b0;
    nop_bundle();
    chk_ctl("post_rst_ctl", 5'b00000);
    chk_sel("post_rst_sel", 3'd0, 3'd0, 3'd0, 3'd0);

    // c0: A add x5,x1,x2
    set_a(5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);
    chk_ctl("c0_ctl", 5'b00000);
    tick();
    // c1: A sub x6,x5,x1
    set_a(5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0);
    chk_ctl("c1_ctl", 5'b00000);
    chk_sel("c1_sel", 3'd0, 3'd0, 3'd0, 3'd0);
    tick();
    // c2: sub in EX, add in MEM; ID: A or x7,x5,x0 / B and x10,x5,x6
    chk_sel("c2_sub", 3'd1, 3'd0, 3'd0, 3'd0);
    set_a(5'd5, 1'b1, 5'd0, 1'b1, 5'd7, 1'b1, 1'b0);
    set_b(5'd5, 1'b1, 5'd6, 1'b1, 5'd10, 1'b1, 1'b0);
    chk_ctl("c2_ctl", 5'b00000);
    tick();
    // c3: add in WB, sub in MEM
    nop_bundle();
    chk_sel("c3_wb", 3'd2, 3'd0, 3'd2, 3'd1);
    tick();

    // c4: A and B both write x7
    set_a(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
    set_b(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
    tick();
    // c5: readers of x7
    set_a(5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    set_b(5'd0, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0);
    tick();
    // c6: B_FWD_MEM beats A_FWD_MEM; ID: A reads x7, inactive rs2=x7, B reads x0
    chk_sel("c6_memprio", 3'd3, 3'd0, 3'd0, 3'd3);
    set_a(5'd7, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 1'b0);
    set_b(5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
    // c7: both x7 writers in WB -> B_FWD_WB
    nop_bundle();
    chk_sel("c7_wbprio", 3'd4, 3'd0, 3'd0, 3'd0);
    tick();

    // c8: A lw x8
    set_a(5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1);
    chk_ctl("c8_ctl", 5'b00000);
    tick();
    // c9: B add x9,x8,x8 -> load-use stall
    set_a(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    set_b(5'd8, 1'b1, 5'd8, 1'b1, 5'd9, 1'b1, 1'b0);
    chk_ctl("c9_ldstall", 5'b11100);
    tick();
    // c10: LD_STALL re-evaluates, issues; load in MEM never forwarded
    chk_ctl("c10_issue", 5'b00000);
    chk_sel("c10_memld", 3'd0, 3'd0, 3'd0, 3'd0);
    tick();
    // c11: lw in WB
    nop_bundle();
    chk_sel("c11_ldwb", 3'd0, 3'd0, 3'd2, 3'd2);
    tick();

    // c12: A addi x3 / B add x4,x3,x0 -> split
    set_a(5'd1, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0);
    set_b(5'd3, 1'b1, 5'd0, 1'b1, 5'd4, 1'b1, 1'b0);
    chk_ctl("c12_splitA", 5'b10100);
    tick();
    chk_ctl("c13_splitB", 5'b01000);
    tick();
    nop_bundle();
    chk_sel("c14_split_sel", 3'd0, 3'd0, 3'd1, 3'd0);
    tick();

    // c15: A lw x3 / B reads x3 on rs2 -> split with wait
    set_a(5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1);
    set_b(5'd0, 1'b0, 5'd3, 1'b1, 5'd11, 1'b1, 1'b0);
    chk_ctl("c15_splitA", 5'b10100);
    tick();
    chk_ctl("c16_wait", 5'b11100);
    tick();
    chk_ctl("c17_splitB", 5'b01000);
    tick();
    nop_bundle();
    chk_sel("c18_wb", 3'd0, 3'd0, 3'd0, 3'd2);
    tick();

    // c19: same load split, flushed during SPLIT_WAIT
    set_a(5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1);
    set_b(5'd3, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 1'b0);
    chk_ctl("c19_splitA", 5'b10100);
    tick();
    bus.br_flush = 1'b1;
    chk_ctl("c20_flush", 5'b01111);
    tick();
    bus.br_flush = 1'b0;
    set_a(5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    set_b(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    chk_ctl("c21_idle", 5'b00000);
    tick();
    nop_bundle();
    chk_sel("c22_nostale", 3'd0, 3'd0, 3'd0, 3'd0);
    tick();

    // c23: split started, then reset abandons it
    set_a(5'd1, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0);
    set_b(5'd3, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0);
    chk_ctl("c23_splitA", 5'b10100);
    tick();
    rst = 1'b1;
    chk_ctl("c24_rst", 5'b00000);
    tick();
    rst = 1'b0;
    nop_bundle();
    chk_ctl("c25_abandon", 5'b00000);
    chk_sel("c25_sel", 3'd0, 3'd0, 3'd0, 3'd0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
